// File: rtl/div32_seq.sv
// Iterative restoring divider: one quotient bit per clock, MSB first, with
// signed or unsigned operands and a short path for divide-by-zero and overflow.
module div32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH-1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r, q, d;
  logic             neg_q, neg_r;

  logic             a_neg, b_neg, is_zero, is_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0]   trial;

  // -MIN_NEG wraps to MIN_NEG, which is exactly 2^31 read as unsigned
  assign a_neg   = sign & dividend[WIDTH-1];
  assign b_neg   = sign & divisor[WIDTH-1];
  assign a_mag   = a_neg ? -dividend : dividend;
  assign b_mag   = b_neg ? -divisor  : divisor;
  assign is_zero = (divisor == '0);
  assign is_ovf  = sign && (dividend == MIN_NEG) && (divisor == '1);

  // Borrow out of the 33-bit trial subtraction means restore
  assign trial = {r, q[WIDTH-1]} - {1'b0, d};
  assign q_fix = neg_q ? -q : q;
  assign r_fix = (neg_r && (r != '0)) ? -r : r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            r        <= '0;
            q        <= a_mag;
            d        <= b_mag;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            cnt      <= '0;
            if (is_zero) begin
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else if (is_ovf) begin
              quotient  <= MIN_NEG;
              remainder <= '0;
              ovf       <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (trial[WIDTH]) begin
            r <= {r[WIDTH-2:0], q[WIDTH-1]};
            q <= {q[WIDTH-2:0], 1'b0};
          end else begin
            r <= trial[WIDTH-1:0];
            q <= {q[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) state <= FIX;
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
- Iterative 32-bit integer divider: one restoring-division step per clock, signed or unsigned operands.
- Sits beside the ALU adder/subtractor as the multi-cycle arithmetic stage.
- Takes operands from the operand registers; returns quotient, remainder and status to the result/flags writeback.
- Each step's trial subtraction is a 33-bit subtract, where borrow means "restore".

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported and verified.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- sign  input  1  1 = signed (two's complement), 0 = unsigned; sampled with start
- dividend  input  32  numerator; sampled with start
- divisor  input  32  denominator; sampled with start
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  32  result quotient; held until the next accepted start
- remainder  output  32  result remainder; held until the next accepted start
- div_zero  output  1  divisor was 0; held with the results
- ovf  output  1  signed case -2^31 / -1; held with the results

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_zero=0, ovf=0; internal registers and counter cleared. Reset mid-CALC aborts the division with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1:
  - Latch the operands and sign; clear div_zero and ovf.
  - divisor==0 -> DONE next cycle: quotient=32'hFFFFFFFF, remainder=dividend, div_zero=1.
  - sign=1, dividend=32'h80000000, divisor=32'hFFFFFFFF -> DONE: quotient=32'h80000000, remainder=0, ovf=1.
  - Otherwise -> CALC: busy=1, counter=0.
  - In signed mode each operand's magnitude is loaded (negate if bit31=1); negation of 32'h80000000 yields 32'h80000000, treated as unsigned 2^31.
- CALC, one step per cycle, MSB first:
  - Compute trial = {R,Q[31]} - {1'b0,D} in 33 bits.
  - No borrow: R=trial[31:0], shift Q left inserting 1.
  - Borrow: R={R[30:0],Q[31]}, shift Q left inserting 0.
  - After the 32nd step (counter==31) -> FIX.
- FIX, one cycle:
  - Signed: negate the quotient if the operand signs differ; the remainder takes the dividend's sign (negate if dividend negative and R != 0).
  - Unsigned: pass through.
  - Load the quotient and remainder outputs -> DONE.
- DONE, one cycle: done=1, busy=0 -> IDLE.
- Latency: normal case, start accepted at cycle 0 gives done at cycle 34 (32 CALC + FIX + DONE). Divide-by-zero and overflow: done at cycle 1.
- busy: high from the cycle after start acceptance through FIX; low in DONE and IDLE. The zero/overflow short path never raises busy.
- start while busy or in DONE: ignored, no queuing. start in the same cycle done is high: ignored; it must be reasserted in IDLE.
- Operand inputs may change freely after acceptance; the latched copies are used.
- Outputs change only in FIX / the short-path DONE entry; they are stable from done until the next acceptance.
- Invariant, non-error cases: dividend == quotient*divisor + remainder (mod 2^32); |remainder| < |divisor|.

Test Plan:
- Unsigned 100 / 7, sign=0 -> done at cycle 34, quotient=14, remainder=2, div_zero=0, ovf=0; busy high cycles 1..33.
- Signed -7 / 2 (32'hFFFFFFF9, 2) -> quotient=32'hFFFFFFFD (-3), remainder=32'hFFFFFFFF (-1); 7 / -2 -> quotient=-3, remainder=1.
- Divide by zero: 1234 / 0 unsigned -> done at cycle 1, quotient=32'hFFFFFFFF, remainder=1234, div_zero=1, busy never high.
- Signed overflow: 32'h80000000 / 32'hFFFFFFFF -> quotient=32'h80000000, remainder=0, ovf=1. Same operands with sign=0 -> quotient=0, remainder=32'h80000000, ovf=0.
- Extremes: unsigned 32'hFFFFFFFF / 1 -> quotient=32'hFFFFFFFF, remainder=0. Unsigned 5 / 32'hFFFFFFFF -> quotient=0, remainder=5. Signed 32'h80000000 / 2 -> quotient=32'hC0000000, remainder=0.
- Control:
  - start pulsed at cycles 5 and 20 during a busy division -> ignored; results match the first operands.
  - rst asserted at cycle 10 of CALC -> all outputs 0 immediately, no done pulse.
  - A new start after reset computes correctly.
  - 1000 random signed/unsigned pairs are checked against a reference model.
